// File: rtl/hv_timing_gen.sv
// hv_timing_gen -- parametrised H/V video timing generator.
//
// Runs on MCLK and advances only on the PCE pixel clock-enable. It produces
// pixel coordinates for the game core and blank/sync/DE aligned with the
// core's pixel output. It also registers the core's RGB into a blank-gated
// output.
//
// Parameters
//   HACT/HFP/HSW/HBP  horizontal active/front porch/sync width/back porch (pixels)
//   VACT/VFP/VSW/VBP  vertical active/front porch/sync width/back porch (lines)
//   RGBW              RGB bus width
//   PIPE              core pixel latency in CEs (1..4)
//
// Ports
//   MCLK        system clock
//   RESET       synchronous active-high reset
//   PCE         pixel clock enable
//   HADJ/VADJ   signed sync shifts, sampled on the last CE of a frame
//   iRGB        core pixel for the coordinates issued PIPE CEs earlier
//   HPOS/VPOS   current horizontal/vertical counters
//   oRGB        registered RGB, forced to zero during blank
//   HBLK/VBLK   blanking, delayed PIPE CEs
//   HSYN/VSYN   active-low syncs, delayed PIPE CEs
//   DE          ~(HBLK|VBLK)
//   LSTB        one-MCLK pulse after the CE on which hcnt wraps to 0
//   FSTB        one-MCLK pulse after the CE on which hcnt=0 and vcnt=0
//   CSYN        composite sync, active low (only with HV_TIMING_GEN_CSYNC_EN)
//
// Optional feature macro: HV_TIMING_GEN_CSYNC_EN adds the CSYN output.
module hv_timing_gen #(
  parameter int HACT = 288,
  parameter int HFP  = 21,
  parameter int HSW  = 32,
  parameter int HBP  = 43,
  parameter int VACT = 224,
  parameter int VFP  = 10,
  parameter int VSW  = 8,
  parameter int VBP  = 21,
  parameter int RGBW = 12,
  parameter int PIPE = 1
) (
  input  logic            MCLK,
  input  logic            RESET,
  input  logic            PCE,
  input  logic [3:0]      HADJ,
  input  logic [3:0]      VADJ,
  input  logic [RGBW-1:0] iRGB,
  output logic [8:0]      HPOS,
  output logic [8:0]      VPOS,
  output logic [RGBW-1:0] oRGB,
  output logic            HBLK,
  output logic            VBLK,
  output logic            HSYN,
  output logic            VSYN,
  output logic            DE,
  output logic            LSTB,
`ifdef HV_TIMING_GEN_CSYNC_EN
  output logic            FSTB,
  output logic            CSYN
`else
  output logic            FSTB
`endif
);

  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;

  generate
    if (HTOT > 512 || VTOT > 512) begin : g_bad_total
      $error("hv_timing_gen: HTOT and VTOT must not exceed 512");
    end
    if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
      $error("hv_timing_gen: PIPE must be in 1..4");
    end
  endgenerate

  localparam logic [9:0] HACT_C  = 10'(HACT);
  localparam logic [9:0] VACT_C  = 10'(VACT);
  localparam logic [9:0] HS_BASE = 10'(HACT + HFP);
  localparam logic [9:0] VS_BASE = 10'(VACT + VFP);
  localparam logic [9:0] HSW_C   = 10'(HSW);
  localparam logic [9:0] VSW_C   = 10'(VSW);
  localparam logic [8:0] HLAST   = 9'(HTOT - 1);
  localparam logic [8:0] VLAST   = 9'(VTOT - 1);

  // Offset limits: sync must start at least one pixel/line after active
  // video ends and must finish no later than the end of the line/frame.
  localparam int HADJ_LO = 1 - HFP;
  localparam int HADJ_HI = HBP;
  localparam int VADJ_LO = 1 - VFP;
  localparam int VADJ_HI = VBP;

  // Clamped offset kept as a 10-bit two's complement value so it can be
  // added straight onto the nominal sync start.
  function automatic logic [9:0] clamp_adj(input logic [3:0] adj, input int lo, input int hi);
    int v;
    v = int'($signed(adj));
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return 10'(v);
  endfunction

  logic [8:0]      hcnt_reg, vcnt_reg;
  logic [9:0]      ha_reg, va_reg;
  logic [3:0]      pipe_reg [PIPE];   // {hblank, vblank, hsync, vsync}
  logic [RGBW-1:0] rgb_reg;
  logic            lstb_reg, fstb_reg;

  logic [9:0] h_ext, v_ext;
  logic [9:0] hs_start, hs_end, vs_start, vs_end;
  logic       hblank_raw, vblank_raw, hsync_raw, vsync_raw;
  logic [3:0] raw_vec;
  logic [3:0] stage_next;             // value entering the output stage this CE
  logic       line_end, frame_end;

  assign h_ext    = {1'b0, hcnt_reg};
  assign v_ext    = {1'b0, vcnt_reg};
  assign hs_start = HS_BASE + ha_reg;
  assign hs_end   = hs_start + HSW_C;
  assign vs_start = VS_BASE + va_reg;
  assign vs_end   = vs_start + VSW_C;

  assign hblank_raw = (h_ext >= HACT_C);
  assign vblank_raw = (v_ext >= VACT_C);
  assign hsync_raw  = ~((h_ext >= hs_start) && (h_ext < hs_end));
  assign vsync_raw  = ~((v_ext >= vs_start) && (v_ext < vs_end));
  assign raw_vec    = {hblank_raw, vblank_raw, hsync_raw, vsync_raw};

  assign line_end  = (hcnt_reg == HLAST);
  assign frame_end = line_end && (vcnt_reg == VLAST);

  // oRGB gating (and CSYN) must follow the same delayed timing that lands
  // in the output stage on this CE, not the value it is replacing.
  generate
    if (PIPE == 1) begin : g_stage_direct
      assign stage_next = raw_vec;
    end else begin : g_stage_piped
      assign stage_next = pipe_reg[PIPE-2];
    end
  endgenerate

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
      ha_reg   <= '0;
      va_reg   <= '0;
      for (int i = 0; i < PIPE; i++) pipe_reg[i] <= 4'b1111;
      rgb_reg  <= '0;
      lstb_reg <= 1'b0;
      fstb_reg <= 1'b0;
    end else begin
      lstb_reg <= 1'b0;
      fstb_reg <= 1'b0;
      if (PCE) begin
        if (line_end) begin
          hcnt_reg <= '0;
          vcnt_reg <= (vcnt_reg == VLAST) ? 9'd0 : vcnt_reg + 9'd1;
        end else begin
          hcnt_reg <= hcnt_reg + 9'd1;
        end
        // Latch offsets only at the frame boundary so a frame never sees a
        // sync window that moves partway through.
        if (frame_end) begin
          ha_reg <= clamp_adj(HADJ, HADJ_LO, HADJ_HI);
          va_reg <= clamp_adj(VADJ, VADJ_LO, VADJ_HI);
        end
        pipe_reg[0] <= raw_vec;
        for (int i = 1; i < PIPE; i++) pipe_reg[i] <= pipe_reg[i-1];
        rgb_reg  <= (stage_next[3] | stage_next[2]) ? '0 : iRGB;
        lstb_reg <= line_end;
        fstb_reg <= (hcnt_reg == 9'd0) && (vcnt_reg == 9'd0);
      end
    end
  end

`ifdef HV_TIMING_GEN_CSYNC_EN
  logic csyn_reg;

  // XNOR of the active-low syncs: low during either sync alone, high again
  // where hsync overlaps vsync (serration).
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      csyn_reg <= 1'b1;
    end else if (PCE) begin
      csyn_reg <= ~(stage_next[1] ^ stage_next[0]);
    end
  end

  assign CSYN = csyn_reg;
`endif

  assign HPOS = hcnt_reg;
  assign VPOS = vcnt_reg;
  assign oRGB = rgb_reg;
  assign HBLK = pipe_reg[PIPE-1][3];
  assign VBLK = pipe_reg[PIPE-1][2];
  assign HSYN = pipe_reg[PIPE-1][1];
  assign VSYN = pipe_reg[PIPE-1][0];
  assign DE   = ~(pipe_reg[PIPE-1][3] | pipe_reg[PIPE-1][2]);
  assign LSTB = lstb_reg;
  assign FSTB = fstb_reg;

endmodule

// File: tb/tb_hv_timing_gen.sv
// Bench for hv_timing_gen using a reduced raster (31 x 18) so that several
// whole frames fit in a short run. PIPE=2 exercises the delay chain, and the
// small porches make random HADJ/VADJ values hit both clamp limits.
module tb_hv_timing_gen;

  localparam int HACT = 16;
  localparam int HFP  = 4;
  localparam int HSW  = 6;
  localparam int HBP  = 5;
  localparam int VACT = 10;
  localparam int VFP  = 3;
  localparam int VSW  = 2;
  localparam int VBP  = 3;
  localparam int RGBW = 12;
  localparam int PIPE = 2;
  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;
  localparam int FTOT = HTOT * VTOT;

  logic            mclk = 1'b0;
  logic            reset, pce;
  logic [3:0]      hadj, vadj;
  logic [RGBW-1:0] irgb;
  logic [8:0]      hpos, vpos;
  logic [RGBW-1:0] orgb;
  logic            hblk, vblk, hsyn, vsyn, de, lstb, fstb;
`ifdef HV_TIMING_GEN_CSYNC_EN
  logic            csyn;
`endif

  hv_timing_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .RGBW(RGBW), .PIPE(PIPE)
  ) dut (
    .MCLK(mclk), .RESET(reset), .PCE(pce), .HADJ(hadj), .VADJ(vadj), .iRGB(irgb),
    .HPOS(hpos), .VPOS(vpos), .oRGB(orgb), .HBLK(hblk), .VBLK(vblk),
    .HSYN(hsyn), .VSYN(vsyn), .DE(de), .LSTB(lstb),
`ifdef HV_TIMING_GEN_CSYNC_EN
    .FSTB(fstb), .CSYN(csyn)
`else
    .FSTB(fstb)
`endif
  );

  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame position as a single linear index, timing from
  // the raster rules, and a queue standing in for the PIPE-CE delay.
  int              pos, ha_m, va_m;
  logic [3:0]      pq[$];
  logic [3:0]      m_out;
  logic [RGBW-1:0] m_rgb;
  logic            m_lstb, m_fstb, m_csyn;
  int              lcnt, decnt;
  bit              win_valid;

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [3:0] raw_at(int p, int ha, int va);
    int h, v;
    logic hb, vb, hs, vs;
    h  = p % HTOT;
    v  = p / HTOT;
    hb = (h >= HACT);
    vb = (v >= VACT);
    hs = !((h >= HACT + HFP + ha) && (h < HACT + HFP + ha + HSW));
    vs = !((v >= VACT + VFP + va) && (v < VACT + VFP + va + VSW));
    return {hb, vb, hs, vs};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos  = 0;
    ha_m = 0;
    va_m = 0;
    pq.delete();
    for (int i = 0; i < PIPE; i++) pq.push_back(4'hF);
    m_out     = 4'hF;
    m_rgb     = '0;
    m_lstb    = 1'b0;
    m_fstb    = 1'b0;
    m_csyn    = 1'b1;
    win_valid = 1'b0;
  endtask

  task automatic model_ce();
    pq.push_back(raw_at(pos, ha_m, va_m));
    void'(pq.pop_front());
    m_out  = pq[0];
    m_rgb  = (m_out[3] | m_out[2]) ? '0 : irgb;
    m_lstb = ((pos % HTOT) == HTOT - 1);
    m_fstb = (pos == 0);
    m_csyn = ~(m_out[1] ^ m_out[0]);
    if (pos == FTOT - 1) begin
      ha_m = clampi(int'($signed(hadj)), 1 - HFP, HBP);
      va_m = clampi(int'($signed(vadj)), 1 - VFP, VBP);
    end
    pos = (pos + 1) % FTOT;
  endtask

  // One MCLK: let the edge happen with the inputs as driven, advance the
  // model with the same inputs, then compare everything 1 ns later.
  task automatic step();
    @(posedge mclk);
    #1;
    if (reset) model_reset();
    else if (pce) model_ce();
    else begin
      m_lstb = 1'b0;
      m_fstb = 1'b0;
    end
    check("pos", 64'({hpos, vpos}), 64'({9'(pos % HTOT), 9'(pos / HTOT)}));
    check("timing", 64'({hblk, vblk, hsyn, vsyn, de}), 64'({m_out, ~(m_out[3] | m_out[2])}));
    check("rgb", 64'(orgb), 64'(m_rgb));
    check("strobe", 64'({lstb, fstb}), 64'({m_lstb, m_fstb}));
`ifdef HV_TIMING_GEN_CSYNC_EN
    check("csyn", 64'(csyn), 64'(m_csyn));
`endif
    // Per-frame totals measured on the DUT outputs between FSTB pulses.
    if (!reset && pce) begin
      if (fstb) begin
        if (win_valid) begin
          check("lstb_per_frame", 64'(lcnt), 64'(VTOT));
          check("de_per_frame", 64'(decnt), 64'(HACT * VACT));
        end
        lcnt      = 0;
        decnt     = 0;
        win_valid = 1'b1;
      end
      if (lstb) lcnt++;
      if (de) decnt++;
    end
  endtask

  task automatic randomize_inputs();
    pce  = ($urandom_range(0, 2) != 0);
    irgb = RGBW'($urandom());
    hadj = 4'($urandom());
    vadj = 4'($urandom());
  endtask

  initial begin
    int target;
    lcnt  = 0;
    decnt = 0;
    reset = 1'b1;
    pce   = 1'b0;
    hadj  = 4'd0;
    vadj  = 4'd0;
    irgb  = '0;

    // Reset holds everything regardless of PCE.
    for (int i = 0; i < 3; i++) begin
      pce  = 1'(i);
      irgb = RGBW'($urandom());
      step();
    end
    reset = 1'b0;

    // Random run over several frames, with a stretch of PCE held low.
    for (int i = 0; i < 6000; i++) begin
      randomize_inputs();
      if (i >= 3000 && i < 3030) pce = 1'b0;
      step();
    end

    // Reset in the middle of a line and frame with PCE active.
    target = 5 * HTOT + 15;
    pce = 1'b1;
    for (int n = 0; n < 2 * FTOT && pos != target; n++) begin
      irgb = RGBW'($urandom());
      step();
    end
    check("seek_mid_frame", 64'({hpos, vpos}), 64'({9'd15, 9'd5}));
    reset = 1'b1;
    pce   = 1'b1;
    step();
    reset = 1'b0;

    // Recovery after the mid-frame reset.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
